mem_responder: RTL and testbench

Memory-side responder for the single-outstanding request/response port driven by the core's address-translation unit. It accepts one request at a time: a one-cycle `request_enable` pulse with mode, address, write data and byte strobes. It performs the access on an internal word-addressed synchronous block RAM and returns a one-cycle `response_enable` pulse with read data after a fixed, parameterised latency. It sits between the translation unit and physical memory and is the reference target for bringing up paging, since page-table walks and data accesses both terminate here.

---
 rtl/mem_responder_if.sv | 38 +++
 rtl/mem_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Request/response bundle between the address-translation unit (master)
// and the memory-side responder (slave).
//
// Signals:
//   request_enable  master->slave  one-cycle request strobe
//   req_mode        master->slave  0 = read, 1 = write
//   req_addr        master->slave  byte address
//   req_wdata       master->slave  write data
//   req_wstrb       master->slave  byte-lane enables, bit i covers [8i+7:8i]
//   response_enable slave->master  one-cycle completion strobe
//   resp_data       slave->master  read data (0 for writes and faults)
//   access_fault    slave->master  request was rejected
//   busy            slave->master  responder is not idle
//   overrun         slave->master  sticky: a request arrived while busy

interface mem_responder_if;
  logic        request_enable;
  logic        req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        response_enable;
  logic [31:0] resp_data;
  logic        access_fault;
  logic        busy;
  logic        overrun;

  modport master (
    output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  response_enable, resp_data, access_fault, busy, overrun
  );

  modport slave (
    input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output response_enable, resp_data, access_fault, busy, overrun
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for a single-outstanding request port. Accepts one
// request at a time, performs it on an internal word-addressed block RAM and
// answers with a one-cycle response pulse after 3+EXTRA_LATENCY cycles.
//
// Parameters:
//   ADDR_WIDTH     log2 of RAM depth in 32-bit words
//   BASE_ADDR      byte address of word 0 (aligned to 4*2^ADDR_WIDTH)
//   EXTRA_LATENCY  additional wait cycles before responding (0..15)
//
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   mem_responder_if slave modport (request in, response out)

module mem_responder #(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned EXTRA_LATENCY = 0
) (
  input  logic            clk,
  input  logic            rstn,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESPOND
  } state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(EXTRA_LATENCY);
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   wordIdx_q, wordIdx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic                    fault_q, fault_d;
  logic [3:0]              waitCnt_q, waitCnt_d;
  logic                    respEnable_q, respEnable_d;
  logic [31:0]             respData_q, respData_d;
  logic                    accessFault_q, accessFault_d;
  logic                    overrun_q, overrun_d;

  logic [31:0]             readData_q;
  logic [31:0]             mem [0:DEPTH-1];

  logic [32:0]             addrOffset;
  logic                    reqFault;
  logic                    ramWrite;
  logic                    ramRead;

  // Offset from the window base, one bit wider so an address below the base
  // shows up as a set borrow bit. Since the base is aligned to the window
  // size, the address is inside the window exactly when every bit above the
  // word index is zero (borrow included).
  assign addrOffset = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign reqFault   = (addrOffset[1:0] != 2'b00) ||
                      ((addrOffset >> (ADDR_WIDTH + 2)) != 33'd0);

  // The write is qualified with rstn so a reset landing on the edge that
  // leaves ACCESS abandons the write along with the rest of the request.
  assign ramWrite = (state_q == ACCESS) && !fault_q && mode_q && rstn;
  assign ramRead  = (state_q == ACCESS) && !fault_q && !mode_q;

  // Block RAM with per-byte write enables and a registered read port.
  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ramWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) begin
          mem[wordIdx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
    if (ramRead) begin
      readData_q <= mem[wordIdx_q];
    end
  end

  // Controller state and response registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      wordIdx_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      fault_q       <= 1'b0;
      waitCnt_q     <= '0;
      respEnable_q  <= 1'b0;
      respData_q    <= '0;
      accessFault_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      wordIdx_q     <= wordIdx_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      fault_q       <= fault_d;
      waitCnt_q     <= waitCnt_d;
      respEnable_q  <= respEnable_d;
      respData_q    <= respData_d;
      accessFault_q <= accessFault_d;
      overrun_q     <= overrun_d;
    end
  end

  // Next-state logic. The response pulse and fault flag default low so they
  // only last the single cycle after the WAIT->RESPOND edge; resp_data holds.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    wordIdx_d     = wordIdx_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    fault_d       = fault_q;
    waitCnt_d     = waitCnt_q;
    respEnable_d  = 1'b0;
    respData_d    = respData_q;
    accessFault_d = 1'b0;
    overrun_d     = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (bus.request_enable) begin
          mode_d    = bus.req_mode;
          wordIdx_d = addrOffset[ADDR_WIDTH+1:2];
          wdata_d   = bus.req_wdata;
          wstrb_d   = bus.req_wstrb;
          fault_d   = reqFault;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        waitCnt_d = WAIT_LOAD;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else begin
          respEnable_d  = 1'b1;
          respData_d    = (mode_q || fault_q) ? 32'h0 : readData_q;
          accessFault_d = fault_q;
          state_d       = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Requests arriving while a transaction is in flight are dropped.
    if (bus.request_enable && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  assign bus.response_enable = respEnable_q;
  assign bus.resp_data       = respData_q;
  assign bus.access_fault    = accessFault_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed test of mem_responder: one instance with EXTRA_LATENCY = 0 for
// functional tests and one with EXTRA_LATENCY = 5 for the latency sweep.
// Both share clock and reset.

module tb_mem_responder;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus5 ();

  mem_responder #(
    .ADDR_WIDTH    (14),
    .BASE_ADDR     (32'h0000_0000),
    .EXTRA_LATENCY (0)
  ) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  mem_responder #(
    .ADDR_WIDTH    (14),
    .BASE_ADDR     (32'h0000_0000),
    .EXTRA_LATENCY (5)
  ) dut5 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus5)
  );

  int checks = 0;
  int errors = 0;
  int respCount0 = 0;

  // Count every response pulse of the latency-0 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus0.response_enable) respCount0++;
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the request side of one of the two buses.
  task automatic drive(input bit sel, input logic en, input logic mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    if (sel) begin
      bus5.request_enable = en;
      bus5.req_mode       = mode;
      bus5.req_addr       = addr;
      bus5.req_wdata      = wdata;
      bus5.req_wstrb      = strb;
    end else begin
      bus0.request_enable = en;
      bus0.req_mode       = mode;
      bus0.req_addr       = addr;
      bus0.req_wdata      = wdata;
      bus0.req_wstrb      = strb;
    end
  endtask

  // Issue one request and wait (bounded) for its response. lat counts the
  // falling edges after the strobe was driven until response_enable is seen;
  // 0 means no response arrived. busyOk says busy was high throughout, tailOk
  // says the following cycle shows pulse and fault low, data held, not busy.
  task automatic applyStimulus(input bit sel, input logic mode,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb,
                               output logic [31:0] rData, output logic rFault,
                               output int lat, output logic busyOk,
                               output logic tailOk);
    logic        resp;
    logic        flt;
    logic        bsy;
    logic [31:0] dat;
    @(negedge clk);
    drive(sel, 1'b1, mode, addr, wdata, strb);
    lat    = 0;
    busyOk = 1'b1;
    tailOk = 1'b0;
    rData  = '0;
    rFault = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      resp = sel ? bus5.response_enable : bus0.response_enable;
      flt  = sel ? bus5.access_fault    : bus0.access_fault;
      bsy  = sel ? bus5.busy            : bus0.busy;
      dat  = sel ? bus5.resp_data       : bus0.resp_data;
      if (!bsy) busyOk = 1'b0;
      if (resp) begin
        lat    = k;
        rData  = dat;
        rFault = flt;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      resp = sel ? bus5.response_enable : bus0.response_enable;
      flt  = sel ? bus5.access_fault    : bus0.access_fault;
      bsy  = sel ? bus5.busy            : bus0.busy;
      dat  = sel ? bus5.resp_data       : bus0.resp_data;
      tailOk = !resp && !flt && !bsy && (dat == rData);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        f;
    int          lat;
    logic        bOk;
    logic        tOk;
    int          startCount;

    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    checkOutput("rst_resp_en", bus0.response_enable, 1'b0);
    checkOutput("rst_resp_data", bus0.resp_data, 32'h0);
    checkOutput("rst_fault", bus0.access_fault, 1'b0);
    checkOutput("rst_busy", bus0.busy, 1'b0);
    checkOutput("rst_overrun", bus0.overrun, 1'b0);
    rstn = 1'b1;

    // Write then read back
    applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("wr100_lat", lat, 3);
    checkOutput("wr100_fault", f, 1'b0);
    checkOutput("wr100_data", d, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rd100_lat", lat, 3);
    checkOutput("rd100_data", d, 32'hDEADBEEF);
    checkOutput("rd100_fault", f, 1'b0);
    checkOutput("rd100_tail", tOk, 1'b1);

    // Byte-lane merge; the first write follows a read so its data must be 0
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h11223344, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("wr200_data", d, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, d, f, lat, bOk, tOk);
    checkOutput("wr200_strb_lat", lat, 3);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("wr200_nostrb_fault", f, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rd200_merge", d, 32'h11BB33DD);

    // Faults
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("wr0_fault", f, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h10000, 32'h0BADBEEF, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("wr_oob_lat", lat, 3);
    checkOutput("wr_oob_fault", f, 1'b1);
    checkOutput("wr_oob_data", d, 32'h0);
    checkOutput("wr_oob_tail", tOk, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h102, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rd_mis_fault", f, 1'b1);
    checkOutput("rd_mis_data", d, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h101, 32'h99999999, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("wr_mis_fault", f, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rd0_after_oob", d, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rd100_after_mis", d, 32'hDEADBEEF);

    // Latency sweep on the EXTRA_LATENCY = 5 instance
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h13579BDF, 4'hF, d, f, lat, bOk, tOk);
    checkOutput("l5_wr_lat", lat, 8);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("l5_rd_lat", lat, 8);
    checkOutput("l5_rd_data", d, 32'h13579BDF);
    checkOutput("l5_busy_span", bOk, 1'b1);
    checkOutput("l5_tail", tOk, 1'b1);

    // Overrun: second strobe one cycle after an accepted read
    checkOutput("ovr_before", bus0.overrun, 1'b0);
    @(posedge clk);
    #1;
    startCount = respCount0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("ovr_resp_count", respCount0 - startCount, 1);
    checkOutput("ovr_flag", bus0.overrun, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("ovr_mem_intact", d, 32'hDEADBEEF);
    checkOutput("ovr_sticky", bus0.overrun, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("ovr_cleared", bus0.overrun, 1'b0);

    // Reset at E1: write abandoned, no response
    applyStimulus(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, d, f, lat, bOk, tOk);
    @(posedge clk);
    #1;
    startCount = respCount0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("rstE1_no_resp", respCount0 - startCount, 0);
    checkOutput("rstE1_idle", bus0.busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rstE1_mem", d, 32'h0);

    // Reset at E2: write already done, still no response
    @(posedge clk);
    #1;
    startCount = respCount0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h5A5A5A5A, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("rstE2_no_resp", respCount0 - startCount, 0);
    applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, d, f, lat, bOk, tOk);
    checkOutput("rstE2_mem", d, 32'h5A5A5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
